// File: rtl/ring_fifo.sv
// Circular-buffer FIFO with pointer-addressed storage, first-word-fall-through read,
// occupancy status, programmable almost-full/almost-empty, sticky error flags and clear.
module ring_fifo #(
  parameter int unsigned DEPTH    = 8,
  parameter int unsigned BITS     = 64,
  parameter int unsigned AF_LEVEL = DEPTH - 2,
  parameter int unsigned AE_LEVEL = 2,
  parameter int unsigned CW       = $clog2(DEPTH + 1)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            clr,
  input  logic            push,
  input  logic [BITS-1:0] d,
  input  logic            pop,
  output logic [BITS-1:0] q,
  output logic            full,
  output logic            empty,
  output logic            almost_full,
  output logic            almost_empty,
  output logic [CW-1:0]   count,
  output logic            ovf,
  output logic            udf
);

  localparam int unsigned   PW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] AF_CNT   = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_CNT   = CW'(AE_LEVEL);

  logic [BITS-1:0] mem_q [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            ovf_q, ovf_d;
  logic            udf_q, udf_d;
  logic            push_ok, pop_ok, mem_we;

  // Explicit compare-and-wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PW'(1);
  endfunction

  // Status is decoded from registered occupancy only.
  assign empty        = (count_q == '0);
  assign full         = (count_q == FULL_CNT);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);
  assign count        = count_q;
  assign ovf          = ovf_q;
  assign udf          = udf_q;
  assign q            = empty ? '0 : mem_q[rd_ptr_q];

  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign mem_we  = ~clr & push_ok;

  // Next-state: clear wins over any request in the same cycle.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = next_ptr(wr_ptr_q);
      if (pop_ok)  rd_ptr_d = next_ptr(rd_ptr_q);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
      if (push & full & ~pop) ovf_d = 1'b1;
      if (pop & empty)        udf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      if (mem_we) mem_q[wr_ptr_q] <= d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

endmodule

// File: doc/ring_fifo.md
# ring_fifo

Parametrised circular-buffer FIFO that succeeds the fixed shift-register delay buffer in the datapath. Storage is addressed by read and write pointers, so data does not move through every stage each cycle. Push and pop are independent, with full/empty/occupancy status, programmable almost-full and almost-empty thresholds, sticky overflow/underflow error flags and a synchronous clear. It sits between producers and consumers that do not run in lockstep, such as operand staging in front of the MAC array and result draining to memory.

## Interface
- DEPTH, 8: number of entries; any integer ≥ 2, not limited to powers of two.
- BITS, 64: data width.
- AF_LEVEL, DEPTH-2: almost_full asserts when count ≥ AF_LEVEL.
- AE_LEVEL, 2: almost_empty asserts when count ≤ AE_LEVEL.
- CW, $clog2(DEPTH+1): derived count width; not overridden.

- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous assert, active-low.
- clr  in  1  synchronous clear; empties the FIFO and clears error flags.
- push  in  1  write request; d is sampled on the edge.
- d  in  BITS  write data.
- pop  in  1  read request; consumes the entry currently on q.
- q  out  BITS  oldest entry (first-word-fall-through); 0 when empty.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- almost_full  out  1  count ≥ AF_LEVEL.
- almost_empty  out  1  count ≤ AE_LEVEL.
- count  out  CW  current occupancy, 0..DEPTH.
- ovf  out  1  sticky: a push was dropped.
- udf  out  1  sticky: a pop was made while empty.

## Operation
- State: storage mem[0..DEPTH-1], wr_ptr, rd_ptr (0..DEPTH-1), count, ovf, udf.
- Reset (rst_n low, asynchronous):
  - mem all 0; pointers, count, ovf and udf all 0.
  - Outputs: q=0, empty=1, full=0, almost_empty=1, almost_full=0, count=0, ovf=0, udf=0.
- Priority each edge: rst_n, then clr, then push/pop.
- clr: pointers, count, ovf and udf go to 0; mem is not cleared. Any push or pop in the same cycle is ignored and sets no flags.
- Accept rules:
  - push_ok = push & (!full | pop).
  - pop_ok = pop & !empty.
- Accepted push: mem[wr_ptr] <= d, and wr_ptr advances.
- Accepted pop: rd_ptr advances.
- Pointer wrap: a pointer at DEPTH-1 goes to 0. This is explicit compare-and-wrap, not a power-of-two mask.
- count changes by push_ok - pop_ok, so it never exceeds DEPTH and never goes below 0.
- Push while full without pop: the push is dropped, storage and pointers are unchanged, and ovf is set.
- Pop while empty: the pop is ignored and udf is set. If push is also asserted, the push is still accepted.
- Push and pop together while full: both are accepted, count stays DEPTH, and ovf does not change.
- Push and pop together with 0 < count < DEPTH: both are accepted and count is unchanged.
- ovf and udf stay set until clr or reset.
- q = mem[rd_ptr] when count ≠ 0, otherwise 0. q is combinational from registered state only; there is no d-to-q combinational path.
- All status outputs are functions of registered count, so they carry no glitch paths from push, pop or d.

## Timing
- Write-to-read latency is 1 cycle: a word pushed at edge N appears on q and drops empty after edge N, visible in cycle N+1.
- A pop at edge N presents the next entry on q in cycle N+1 (or 0 if the FIFO became empty).
- full, empty, almost_* and count all update on the same edge as the pointer change.
- ovf and udf assert on the edge of the offending request and are visible the following cycle.
- Throughput: one push and one pop per cycle sustained, including at full.
- Asynchronous reset mid-operation forces all outputs to their reset values immediately, without waiting for clk. The first valid push is the first edge after rst_n deasserts.

## Test plan
- Reset, then push 1..8 on consecutive cycles (DEPTH=8) -> count 1..8, almost_full at count 6, full at count 8, q=1 from cycle 2 on. Then pop 8 times -> q sequence 1..8, empty=1, q=0, ovf=udf=0.
- Full FIFO, push 0xAA without pop -> ovf=1, count stays 8, drained sequence still 1..8 with no 0xAA. Then clr -> ovf=0, empty=1.
- Empty FIFO, pop alone -> udf=1, count 0. Next, pop and push 0x55 in the same cycle -> count 1, q=0x55, udf stays 1.
- Full FIFO, simultaneous push 9 and pop for 4 cycles -> count stays 8, full stays 1, popped values 1..4, remaining order 5..8 then 9..12.
- DEPTH=5, 23 randomised pushes/pops against a scoreboard -> pointers wrap 4→0, order is preserved, count is always 0..5, flags match the model.
- Midway with count=3, assert clr together with push -> count=0, push ignored. Separately, pulse rst_n low between edges -> q=0 and empty=1 immediately.
